// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM with independent write and read pointers,
// as found behind an SPI slave front end. Each valid command word carries a
// 2-bit opcode and an ADDR_W-bit payload:
//   00 - load wr_addr (range checked)     01 - write payload to MEM[wr_addr]
//   10 - load rd_addr (range checked)     11 - read MEM[rd_addr] onto dout
// With AUTO_INC=1 the pointers advance after each access, wrapping at
// MEM_DEPTH-1, which allows bursts without reloading the address.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous active-low reset (memory contents are kept)
//   rx_valid  - din holds a command this cycle
//   din       - {opcode[1:0], payload[ADDR_W-1:0]}
//   dout      - read data, held until the next read or reset
//   tx_valid  - one-cycle pulse: dout was just loaded by a read
//   addr_err  - one-cycle pulse: an address load was rejected as out of range
module spi_ram_burst #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [ADDR_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        OP_WADDR = 2'b00,
        OP_WRITE = 2'b01,
        OP_RADDR = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    // Pointers never exceed MEM_DEPTH-1, so only the low IDX_W bits index the array.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so MEM_DEPTH = 2**ADDR_W is representable; the range
    // check then never fails and wrap happens naturally at all-ones.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    op_t               op;
    logic [ADDR_W-1:0] payload;
    logic              in_range;
    logic              do_write;

    assign op       = op_t'(din[ADDR_W+1:ADDR_W]);
    assign payload  = din[ADDR_W-1:0];
    assign in_range = {1'b0, payload} < DEPTH_L;
    assign do_write = rst_n && rx_valid && (op == OP_WRITE);

    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage array has no reset branch; clearing it would turn the
    // RAM into a flop array and its contents are not defined after reset anyway.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr[IDX_W-1:0]] <= payload[DATA_W-1:0];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees pre-edge values; a write committed on one edge is visible to a
    // read issued on the next edge without any bypass path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            addr_err <= 1'b0;
            if (rx_valid) begin
                case (op)
                    OP_WADDR: begin
                        if (in_range) wr_addr  <= payload;
                        else          addr_err <= 1'b1;
                    end
                    OP_WRITE: begin
                        if (AUTO_INC != 0) wr_addr <= bump(wr_addr);
                    end
                    OP_RADDR: begin
                        if (in_range) rd_addr  <= payload;
                        else          addr_err <= 1'b1;
                    end
                    OP_READ: begin
                        dout     <= mem[rd_addr[IDX_W-1:0]];
                        tx_valid <= 1'b1;
                        if (AUTO_INC != 0) rd_addr <= bump(rd_addr);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
